pipelined_adder: RTL
====================

Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit with carry-in and carry-out.
- Splits WIDTH-bit operands into CHUNK-bit slices and resolves one slice per pipeline stage, with the carry registered between stages.
- Valid/ready handshake on both sides, with per-stage backpressure and bubble collapse.
- Sits between operand producers (ALU issue, accumulator datapaths) and result consumers; one result per cycle in steady state.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits resolved per stage; 1..WIDTH.
- STAGES, WIDTH/CHUNK, derived; number of pipeline stages and the latency in cycles. Not overridable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
- io_in_valid  in  1  operand beat valid.
- io_in_ready  out  1  unit can accept a beat this cycle.
- io_sub  in  1  0 = add, 1 = subtract.
- io_cin  in  1  carry-in (add) / borrow-in (sub).
- io_lhs  in  WIDTH  left operand.
- io_rhs  in  WIDTH  right operand.
- io_out_valid  out  1  result beat valid.
- io_out_ready  in  1  consumer accepts the result.
- io_out  out  WIDTH  result.
- io_cout  out  1  carry-out (add) / not-borrow (sub).
- io_ovf  out  1  signed two's-complement overflow.

Behaviour:
- Arithmetic:
  - Add: {io_cout, io_out} = lhs + rhs + cin, evaluated at WIDTH+1 bits.
  - Sub: operate as lhs + ~rhs + ~cin, so io_out = lhs - rhs - cin mod 2^WIDTH. io_cout = 1 iff no borrow occurred.
  - io_ovf = (a[MSB] == b[MSB]) && (io_out[MSB] != a[MSB]), where a = lhs and b = effective rhs (rhs, or ~rhs in sub).
- Pipeline:
  - Stage k (0..STAGES-1) adds slice k of a and b plus the registered carry from stage k-1. Stage 0 uses the effective carry-in.
  - Stage k registers its sum slice, the carry, and the not-yet-consumed upper slices of a and b.
  - Lower result slices travel forward alongside the upper operand slices.
  - At accept, the stage-0 register captures sub-adjusted b and effective carry-in; io_sub is not carried further.
- Latency: a beat accepted at edge t is presented on io_out/io_out_valid after edge t+STAGES-1, assuming no stall. STAGES=1 means one cycle.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - Stage k ready = !valid_k || ready_(k+1); the last stage's ready is io_out_ready.
  - io_in_ready = stage-0 ready. It is combinational from io_out_ready through the chain; no registered skid.
  - Bubbles collapse: an empty stage accepts from upstream even while downstream stalls.
  - Outputs hold stable while io_out_valid=1 and io_out_ready=0.
  - io_in_valid must not depend on io_in_ready.
- Full pipeline: with all stages valid and io_out_ready=0, io_in_ready=0 and no state changes.
- Simultaneous events: when full and io_out_ready=1, the unit drains and accepts in the same cycle. Throughput is 1 per cycle.
- Wrap-around: results are modulo 2^WIDTH; the carry chain never saturates.
- Reset (reset=0 at an edge):
  - All stage valid bits clear; io_out_valid=0 and io_in_ready=1 on the following cycle.
  - io_out, io_cout and io_ovf are forced to 0.
  - In-flight beats are discarded, including mid-pipeline. io_in_valid during reset is ignored.
- Data registers other than the output stage need no reset.

Decomposition:
- Shared package holds:
  - op encoding constants ADD=0, SUB=1;
  - a function deriving STAGES and checking WIDTH % CHUNK == 0, failing elaboration otherwise;
  - the result record type {out, cout, ovf}.
- One sub-module, adder_slice_stage: CHUNK-bit add plus carry, carrying the valid bit, payload registers and the local ready equation. pipelined_adder instantiates STAGES of them and handles the sub/cin preprocessing and ovf logic.

Test Plan:
- Defaults (32/8), add 0xFFFFFFFF + 0x00000001, cin=0, out_ready=1 -> after 4 cycles io_out=0x00000000, io_cout=1, io_ovf=0; carry must cross all slices.
- Add 0x7FFFFFFF + 0x00000000, cin=1 -> io_out=0x80000000, io_cout=0, io_ovf=1. Sub 0x00000005 - 0x00000007, cin=0 -> io_out=0xFFFFFFFE, io_cout=0 (borrow), io_ovf=0.
- Stream 100 random beats with out_ready=1 -> one result per cycle, in order, matching the reference model; io_in_ready constantly 1.
- Fill 4 beats, then hold out_ready=0 for 10 cycles -> io_in_ready=0, io_out stable. Release -> 4 results on consecutive cycles, simultaneous with new accepts.
- Bubble collapse: beat A, 2 idle cycles, beat B, with out_ready=0 throughout -> A and B occupy stages 3 and 2, and io_in_ready stays 1 until 4 beats are held.
- Assert reset=0 for one edge with 3 beats in flight -> next cycle io_out_valid=0, io_out=0, io_in_ready=1. No stale result ever appears afterward.
- Config WIDTH=8, CHUNK=8 (STAGES=1): add 0x80 + 0x80 -> io_out=0x00, io_cout=1, io_ovf=1, one-cycle latency.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encoding,
// stage-count derivation and the result flag record.
package pipelined_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // The sum itself travels as a WIDTH-bit vector beside this record, since
    // its width is a parameter of the unit rather than of the package.
    typedef struct packed {
        logic cout;
        logic ovf;
    } result_t;

    // Returns 0 for an illegal WIDTH/CHUNK pairing so the top can refuse to elaborate.
    function automatic int unsigned calc_stages(input int unsigned width,
                                                input int unsigned chunk);
        if (chunk == 0 || chunk > width || (width % chunk) != 0) begin
            return 0;
        end
        return width / chunk;
    endfunction

endpackage

// File: rtl/pipelined_adder_slice_stage.sv
// One pipeline stage: resolves CHUNK bits of the sum, registers the partial
// result, carry and operands, and owns its valid bit and ready equation.
module adder_slice_stage #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CHUNK   = 8,
    parameter int unsigned IDX     = 0,
    parameter bit          IS_LAST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up_valid,
    output logic             up_ready_c,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    input  logic [WIDTH-1:0] sum,
    input  logic             carry,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] lhs_q,
    output logic [WIDTH-1:0] rhs_q,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
    output logic             ovf_q
);

    localparam int unsigned LO  = IDX * CHUNK;
    localparam int unsigned MSB = WIDTH - 1;
    localparam int unsigned SW  = CHUNK + 1;

    logic [SW-1:0]    slice_sum;
    logic [WIDTH-1:0] sum_next;
    logic             ovf_next;
    logic             load;

    // An empty stage accepts even while downstream stalls (bubble collapse).
    assign up_ready_c = !dn_valid || dn_ready;
    assign load       = up_valid && up_ready_c;

    always_comb begin
        slice_sum             = SW'(lhs[LO +: CHUNK]) + SW'(rhs[LO +: CHUNK]) + SW'(carry);
        sum_next              = sum;
        sum_next[LO +: CHUNK] = slice_sum[CHUNK-1:0];
        ovf_next              = (lhs[MSB] == rhs[MSB]) && (sum_next[MSB] != lhs[MSB]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dn_valid <= 1'b0;
        end else if (up_ready_c) begin
            dn_valid <= up_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            lhs_q <= lhs;
            rhs_q <= rhs;
        end
    end

    // Only the output stage clears its result; inner stages are masked by valid.
    always_ff @(posedge clk) begin
        if (IS_LAST && !reset) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (load) begin
            sum_q   <= sum_next;
            carry_q <= slice_sum[CHUNK];
            ovf_q   <= ovf_next;
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: one CHUNK-bit slice per stage with the carry
// registered between stages and valid/ready flow control through the chain.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic             io_sub,
    input  logic             io_cin,
    input  logic [WIDTH-1:0] io_lhs,
    input  logic [WIDTH-1:0] io_rhs,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out,
    output logic             io_cout,
    output logic             io_ovf
);

    localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);

    if (STAGES == 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a nonzero multiple of CHUNK");
    end

    logic [WIDTH-1:0] lhs_pipe   [0:STAGES];
    logic [WIDTH-1:0] rhs_pipe   [0:STAGES];
    logic [WIDTH-1:0] sum_pipe   [0:STAGES];
    logic             carry_pipe [0:STAGES];
    logic             valid_pipe [0:STAGES];
    logic             ovf_pipe   [1:STAGES];
    result_t          result;

    // Subtract is lhs + ~rhs + ~cin; io_sub is consumed here and not carried on.
    assign lhs_pipe[0]   = io_lhs;
    assign rhs_pipe[0]   = (io_sub == OP_SUB) ? ~io_rhs : io_rhs;
    assign carry_pipe[0] = (io_sub == OP_SUB) ? ~io_cin : io_cin;
    assign sum_pipe[0]   = '0;
    assign valid_pipe[0] = io_in_valid;

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        logic ready_c;
        logic dn_ready;

        if (k == int'(STAGES) - 1) begin : g_tail
            assign dn_ready = io_out_ready;
        end else begin : g_body
            assign dn_ready = g_stage[k+1].ready_c;
        end

        adder_slice_stage #(
            .WIDTH   (WIDTH),
            .CHUNK   (CHUNK),
            .IDX     (k),
            .IS_LAST (k == int'(STAGES) - 1)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .up_valid   (valid_pipe[k]),
            .up_ready_c (ready_c),
            .lhs        (lhs_pipe[k]),
            .rhs        (rhs_pipe[k]),
            .sum        (sum_pipe[k]),
            .carry      (carry_pipe[k]),
            .dn_valid   (valid_pipe[k+1]),
            .dn_ready   (dn_ready),
            .lhs_q      (lhs_pipe[k+1]),
            .rhs_q      (rhs_pipe[k+1]),
            .sum_q      (sum_pipe[k+1]),
            .carry_q    (carry_pipe[k+1]),
            .ovf_q      (ovf_pipe[k+1])
        );
    end

    assign io_in_ready  = g_stage[0].ready_c;
    assign io_out_valid = valid_pipe[STAGES];
    assign io_out       = sum_pipe[STAGES];
    assign result       = '{cout: carry_pipe[STAGES], ovf: ovf_pipe[STAGES]};
    assign io_cout      = result.cout;
    assign io_ovf       = result.ovf;

endmodule
